// File: rtl/bcd_para_binario_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
package bcd_para_binario_seq_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        DESLOCA = 2'd1,
        SINAL   = 2'd2
    } estado_t;

    localparam int ITERACOES       = 16;
    localparam int BCD_MAX         = 9;
    localparam int LIMIAR_CORRECAO = 8;

    // True when any of the four packed BCD nibbles is outside 0..9.
    function automatic logic tem_digito_invalido(input logic [15:0] bcd);
        logic inv;
        inv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bcd[i*4 +: 4] > 4'(BCD_MAX)) inv = 1'b1;
        end
        return inv;
    endfunction

endpackage

// File: rtl/bcd_para_binario_seq_if.sv
// Request/result bundle between the digit entry side and the converter.
interface bcd_para_binario_seq_if #(
    parameter int LARGURA_SAIDA = 32
);
    logic                     start;
    logic                     negativo;
    logic [3:0]               milhar;
    logic [3:0]               centena;
    logic [3:0]               dezena;
    logic [3:0]               unidade;
    logic [LARGURA_SAIDA-1:0] numero;
    logic                     ocupado;
    logic                     pronto;
    logic                     erro;

    modport master (
        output start, negativo, milhar, centena, dezena, unidade,
        input  numero, ocupado, pronto, erro
    );

    modport slave (
        input  start, negativo, milhar, centena, dezena, unidade,
        output numero, ocupado, pronto, erro
    );
endinterface

// File: rtl/bcd_para_binario_seq_corrige.sv
// One-digit correction for reverse double dabble: digits >= 8 after a right shift lose 3.
module corrige_digito_bcd
    import bcd_para_binario_seq_pkg::*;
(
    input  logic [3:0] digito_i,
    output logic [3:0] digito_o
);
    assign digito_o = (digito_i >= 4'(LIMIAR_CORRECAO)) ? digito_i - 4'd3 : digito_i;
endmodule

// File: rtl/bcd_para_binario_seq.sv
// Sequential BCD-to-binary converter: 16 shift+correct steps, then sign application.
module bcd_para_binario_seq
    import bcd_para_binario_seq_pkg::*;
#(
    parameter int LARGURA_SAIDA = 32
) (
    input logic                   clock_i,
    input logic                   reset_i,
    bcd_para_binario_seq_if.slave bus
);
    estado_t                  estado_q, estado_d;
    logic [4:0]               contador_q, contador_d;
    logic [15:0]              bcd_q, bcd_d;
    logic [15:0]              bin_q, bin_d;
    logic                     neg_q, neg_d;
    logic                     inv_q, inv_d;
    logic [LARGURA_SAIDA-1:0] numero_q, numero_d;
    logic                     erro_q, erro_d;
    logic                     pronto_q, pronto_d;

    logic [15:0]              bcd_desl;
    logic [15:0]              bcd_corr;
    logic [LARGURA_SAIDA-1:0] bin_ext;

    // The low bcd bit drops into bin[15]; the four nibbles are then corrected in parallel.
    assign bcd_desl = {1'b0, bcd_q[15:1]};

    for (genvar g = 0; g < 4; g++) begin : g_corr
        corrige_digito_bcd u_corr (
            .digito_i (bcd_desl[g*4 +: 4]),
            .digito_o (bcd_corr[g*4 +: 4])
        );
    end

    assign bin_ext = LARGURA_SAIDA'($signed(bin_q));

    // Next-state and datapath updates for the three-state sequencer.
    always_comb begin
        estado_d   = estado_q;
        contador_d = contador_q;
        bcd_d      = bcd_q;
        bin_d      = bin_q;
        neg_d      = neg_q;
        inv_d      = inv_q;
        numero_d   = numero_q;
        erro_d     = erro_q;
        pronto_d   = 1'b0;
        unique case (estado_q)
            OCIOSO: begin
                if (bus.start) begin
                    bcd_d      = {bus.milhar, bus.centena, bus.dezena, bus.unidade};
                    neg_d      = bus.negativo;
                    inv_d      = tem_digito_invalido(bcd_d);
                    bin_d      = '0;
                    contador_d = '0;
                    erro_d     = 1'b0;
                    estado_d   = DESLOCA;
                end
            end
            DESLOCA: begin
                bcd_d      = bcd_corr;
                bin_d      = {bcd_q[0], bin_q[15:1]};
                contador_d = contador_q + 5'd1;
                if (contador_q == 5'(ITERACOES - 1)) estado_d = SINAL;
            end
            SINAL: begin
                // Bad digits keep the previous result; timing is the same either way.
                if (inv_q) erro_d = 1'b1;
                else       numero_d = neg_q ? -bin_ext : bin_ext;
                pronto_d = 1'b1;
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            estado_q   <= OCIOSO;
            contador_q <= '0;
            bcd_q      <= '0;
            bin_q      <= '0;
            neg_q      <= 1'b0;
            inv_q      <= 1'b0;
            numero_q   <= '0;
            erro_q     <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            contador_q <= contador_d;
            bcd_q      <= bcd_d;
            bin_q      <= bin_d;
            neg_q      <= neg_d;
            inv_q      <= inv_d;
            numero_q   <= numero_d;
            erro_q     <= erro_d;
            pronto_q   <= pronto_d;
        end
    end

    assign bus.numero  = numero_q;
    assign bus.ocupado = (estado_q != OCIOSO);
    assign bus.pronto  = pronto_q;
    assign bus.erro    = erro_q;
endmodule

// File: tb/tb_bcd_para_binario_seq.sv
// Bench: 32- and 16-bit converters share stimulus; a decimal-arithmetic model checks every cycle.
module tb_bcd_para_binario_seq;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    bcd_para_binario_seq_if #(.LARGURA_SAIDA(32)) b32 ();
    bcd_para_binario_seq_if #(.LARGURA_SAIDA(16)) b16 ();

    assign b16.start    = b32.start;
    assign b16.negativo = b32.negativo;
    assign b16.milhar   = b32.milhar;
    assign b16.centena  = b32.centena;
    assign b16.dezena   = b32.dezena;
    assign b16.unidade  = b32.unidade;

    bcd_para_binario_seq #(.LARGURA_SAIDA(32)) dut32 (.clock_i(clock), .reset_i(reset), .bus(b32));
    bcd_para_binario_seq #(.LARGURA_SAIDA(16)) dut16 (.clock_i(clock), .reset_i(reset), .bus(b16));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: decimal value, busy countdown of 17 edges, result applied on the last.
    int          m_cnt = 0;
    int          m_val = 0;
    logic        m_inv = 1'b0;
    logic        m_neg = 1'b0;
    logic [31:0] m_num = '0;
    logic        m_pronto = 1'b0;
    logic        m_erro = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_cnt = 0; m_num = '0; m_pronto = 1'b0; m_erro = 1'b0;
        end else begin
            m_pronto = 1'b0;
            if (m_cnt == 0) begin
                if (b32.start) begin
                    m_val = 1000 * int'(b32.milhar) + 100 * int'(b32.centena)
                          + 10 * int'(b32.dezena) + int'(b32.unidade);
                    m_inv = (b32.milhar > 9) || (b32.centena > 9) ||
                            (b32.dezena > 9) || (b32.unidade > 9);
                    m_neg = b32.negativo;
                    m_erro = 1'b0;
                    m_cnt = 17;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    if (m_inv) m_erro = 1'b1;
                    else       m_num = m_neg ? 32'(-m_val) : 32'(m_val);
                    m_pronto = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clock) begin
        chk("numero32", b32.numero, m_num);
        chk("numero16", {16'd0, b16.numero}, {16'd0, m_num[15:0]});
        chk("ocupado32", {31'd0, b32.ocupado}, {31'd0, m_cnt != 0});
        chk("ocupado16", {31'd0, b16.ocupado}, {31'd0, m_cnt != 0});
        chk("pronto32", {31'd0, b32.pronto}, {31'd0, m_pronto});
        chk("pronto16", {31'd0, b16.pronto}, {31'd0, m_pronto});
        chk("erro32", {31'd0, b32.erro}, {31'd0, m_erro});
        chk("erro16", {31'd0, b16.erro}, {31'd0, m_erro});
    end

    // Wait (bounded) for pronto; returns number of negedges seen.
    task automatic wait_pronto(output int lat);
        lat = 1;
        while (!b32.pronto && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        if (!b32.pronto) chk("pronto_timeout", 32'(lat), 32'd18);
    endtask

    // Called at a negedge: pulses start, scrambles inputs, waits for pronto, checks latency.
    task automatic conv(input logic [3:0] m, c, d, u, input logic neg);
        int lat;
        b32.start = 1'b1; b32.negativo = neg;
        b32.milhar = m; b32.centena = c; b32.dezena = d; b32.unidade = u;
        @(negedge clock);
        b32.start = 1'b0;
        b32.negativo = 1'($urandom);
        b32.milhar = 4'($urandom); b32.centena = 4'($urandom);
        b32.dezena = 4'($urandom); b32.unidade = 4'($urandom);
        wait_pronto(lat);
        chk("latencia", 32'(lat), 32'd18);
    endtask

    initial begin
        int lat;
        logic [3:0] dg [4];
        b32.start = 1'b0; b32.negativo = 1'b0;
        b32.milhar = '0; b32.centena = '0; b32.dezena = '0; b32.unidade = '0;
        repeat (2) @(negedge clock);
        chk("reset_numero", b32.numero, 32'd0);
        chk("reset_pronto", {31'd0, b32.pronto}, 32'd0);
        chk("reset_ocupado", {31'd0, b32.ocupado}, 32'd0);
        chk("reset_erro", {31'd0, b32.erro}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // +1234
        conv(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        chk("t1_numero", b32.numero, 32'h0000_04D2);
        chk("t1_model", m_num, 32'h0000_04D2);
        chk("t1_erro", {31'd0, b32.erro}, 32'd0);
        @(negedge clock);

        // -9999 then -0
        conv(4'd9, 4'd9, 4'd9, 4'd9, 1'b1);
        chk("t2_numero", b32.numero, 32'hFFFF_D8F1);
        chk("t2_numero16", {16'd0, b16.numero}, 32'h0000_D8F1);
        conv(4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        chk("t2_zero", b32.numero, 32'd0);
        conv(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);

        // Invalid digit: result held, erro raised, next valid start clears it
        conv(4'd1, 4'd2, 4'hA, 4'd4, 1'b0);
        chk("t3_erro", {31'd0, b32.erro}, 32'd1);
        chk("t3_numero", b32.numero, 32'h0000_04D2);
        @(negedge clock);
        b32.start = 1'b1; b32.milhar = 4'd0; b32.centena = 4'd0;
        b32.dezena = 4'd0; b32.unidade = 4'd7; b32.negativo = 1'b0;
        @(negedge clock);
        b32.start = 1'b0;
        chk("t3_erro_clr", {31'd0, b32.erro}, 32'd0);
        wait_pronto(lat);
        chk("t3_sete", b32.numero, 32'd7);
        @(negedge clock);

        // Reset in the 8th shift cycle aborts
        b32.start = 1'b1; b32.milhar = 4'd0; b32.centena = 4'd0;
        b32.dezena = 4'd0; b32.unidade = 4'd5; b32.negativo = 1'b0;
        @(negedge clock);
        b32.start = 1'b0;
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t4_ocupado", {31'd0, b32.ocupado}, 32'd0);
        chk("t4_numero", b32.numero, 32'd0);
        repeat (25) begin
            @(negedge clock);
            chk("t4_sem_pronto", {31'd0, b32.pronto}, 32'd0);
        end

        // Start while busy is ignored; start in the pronto cycle is accepted
        b32.start = 1'b1; b32.milhar = 4'd0; b32.centena = 4'd0;
        b32.dezena = 4'd4; b32.unidade = 4'd2; b32.negativo = 1'b0;
        @(negedge clock);
        b32.start = 1'b0;
        repeat (4) @(negedge clock);
        b32.start = 1'b1; b32.centena = 4'd7; b32.dezena = 4'd7; b32.unidade = 4'd7;
        @(negedge clock);
        b32.start = 1'b0;
        wait_pronto(lat);
        chk("t5_lat", 32'(lat), 32'd13);
        chk("t5_42", b32.numero, 32'd42);
        conv(4'd0, 4'd7, 4'd7, 4'd7, 1'b0);
        chk("t5_777", b32.numero, 32'd777);

        // 16-bit build: -1
        conv(4'd0, 4'd0, 4'd0, 4'd1, 1'b1);
        chk("t6_16", {16'd0, b16.numero}, 32'h0000_FFFF);
        chk("t6_32", b32.numero, 32'hFFFF_FFFF);

        // Random sweep, occasional bad digit and back-to-back starts
        repeat (80) begin
            for (int i = 0; i < 4; i++) dg[i] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) dg[$urandom_range(0, 3)] = 4'($urandom_range(10, 15));
            conv(dg[0], dg[1], dg[2], dg[3], 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
